ud_counter_arbiter: RTL and testbench

- Shares one up/down counter SFR (ld/incr/decr/D/Q interface, SIZE-bit) among N_REQ requesters.
- Round-robin arbitration selects one requester; its operation (load, increment, decrement, no-op) is issued as a single-cycle strobe to the counter.
- Optional saturation guard refuses increment at all-ones and decrement at zero instead of letting the counter wrap.
- Sits between the sequencing/control logic and the counter SFR; the counter itself is instantiated outside this block.

---
 rtl/ud_counter_arbiter_pkg.sv | 22 ++
 rtl/ud_counter_arbiter_rr_arbiter.sv | 40 ++++
 rtl/ud_counter_arbiter.sv | 119 +++++++++++
 tb/tb_ud_counter_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ud_counter_arbiter_pkg.sv
// Shared definitions for the up/down counter arbiter: op encoding, FSM states
// and the saturation-guard predicate.
package ud_counter_arbiter_pkg;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_INC  = 2'b01;
   localparam logic [1:0] OP_DEC  = 2'b10;
   localparam logic [1:0] OP_LOAD = 2'b11;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_e;

   // True when the op would push the counter past either end of its range.
   function automatic logic sat_refuse(input logic [1:0] op,
                                       input logic       at_max,
                                       input logic       at_zero);
      return ((op == OP_INC) && at_max) || ((op == OP_DEC) && at_zero);
   endfunction

endpackage

// File: rtl/ud_counter_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping modulo N_REQ. The pointer register lives in the parent.
module ud_counter_arbiter_rr_arbiter #(
   parameter  int N_REQ = 4,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N_REQ-1:0] win_oh_o,
   output logic [IDX_W-1:0] win_idx_o,
   output logic             valid_o
);

   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] cand;

   // Walk offsets from farthest to nearest so the nearest hit is written last.
   always_comb begin
      sum       = '0;
      cand      = '0;
      win_idx_o = '0;
      valid_o   = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         sum = {1'b0, ptr_i} + (IDX_W + 1)'(k);
         if (sum >= (IDX_W + 1)'(N_REQ)) begin
            sum = sum - (IDX_W + 1)'(N_REQ);
         end
         cand = sum[IDX_W-1:0];
         if (req_i[cand]) begin
            win_idx_o = cand;
            valid_o   = 1'b1;
         end
      end
   end

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
      assign win_oh_o[gi] = valid_o && (win_idx_o == IDX_W'(gi));
   end

endmodule

// File: rtl/ud_counter_arbiter.sv
// Round-robin front end that shares one up/down counter SFR among N_REQ
// requesters, issuing one registered ld/incr/decr strobe every two cycles.
module ud_counter_arbiter
   import ud_counter_arbiter_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int SIZE     = 5,
   parameter int SATURATE = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [2*N_REQ-1:0]     op,
   input  logic [N_REQ*SIZE-1:0]  data,
   input  logic [SIZE-1:0]        cnt_q,
   output logic                   cnt_ld,
   output logic                   cnt_incr,
   output logic                   cnt_decr,
   output logic [SIZE-1:0]        cnt_d,
   output logic [N_REQ-1:0]       gnt,
   output logic                   err,
   output logic                   busy
);

   localparam int IDX_W = $clog2(N_REQ);

   state_e             state_q;
   logic [IDX_W-1:0]   ptr_q;
   logic [IDX_W-1:0]   ptr_d;
   logic [N_REQ-1:0]   gnt_q;
   logic               err_q;
   logic               busy_q;
   logic               ld_q;
   logic               incr_q;
   logic               decr_q;
   logic [SIZE-1:0]    cnt_d_q;

   logic [1:0]         op_arr   [N_REQ];
   logic [SIZE-1:0]    data_arr [N_REQ];

   logic [N_REQ-1:0]   win_oh;
   logic [IDX_W-1:0]   win_idx;
   logic               win_valid;
   logic [1:0]         win_op;
   logic [SIZE-1:0]    win_data;
   logic               refuse;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign op_arr[gi]   = op[2*gi +: 2];
      assign data_arr[gi] = data[SIZE*gi +: SIZE];
   end

   ud_counter_arbiter_rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_rr (
      .req_i     (req),
      .ptr_i     (ptr_q),
      .win_oh_o  (win_oh),
      .win_idx_o (win_idx),
      .valid_o   (win_valid)
   );

   assign win_op   = op_arr[win_idx];
   assign win_data = data_arr[win_idx];
   assign ptr_d    = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

   // cnt_q is sampled in IDLE; the previous op has already landed by then.
   assign refuse   = (SATURATE != 0) && sat_refuse(win_op, &cnt_q, ~|cnt_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gnt_q   <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         ld_q    <= 1'b0;
         incr_q  <= 1'b0;
         decr_q  <= 1'b0;
         cnt_d_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (win_valid) begin
                  state_q <= ISSUE;
                  ptr_q   <= ptr_d;
                  gnt_q   <= win_oh;
                  busy_q  <= 1'b1;
                  err_q   <= refuse;
                  ld_q    <= (win_op == OP_LOAD);
                  incr_q  <= (win_op == OP_INC) && !refuse;
                  decr_q  <= (win_op == OP_DEC) && !refuse;
                  if (win_op == OP_LOAD) begin
                     cnt_d_q <= win_data;
                  end
               end
            end
            ISSUE: begin
               state_q <= IDLE;
               gnt_q   <= '0;
               err_q   <= 1'b0;
               busy_q  <= 1'b0;
               ld_q    <= 1'b0;
               incr_q  <= 1'b0;
               decr_q  <= 1'b0;
            end
         endcase
      end
   end

   assign cnt_ld   = ld_q;
   assign cnt_incr = incr_q;
   assign cnt_decr = decr_q;
   assign cnt_d    = cnt_d_q;
   assign gnt      = gnt_q;
   assign err      = err_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_ud_counter_arbiter.sv
// Bench for ud_counter_arbiter: a saturating and a wrapping instance share the
// same requesters, each driving its own counter SFR; a transaction model predicts grants.
module tb_ud_counter_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [7:0]  op;
   logic [19:0] data;
   logic        set_en;
   logic [4:0]  set_val;

   logic [4:0]  sfr_s, sfr_w;
   logic        s_ld, s_inc, s_dec, s_err, s_busy;
   logic        w_ld, w_inc, w_dec, w_err, w_busy;
   logic [4:0]  s_d, w_d;
   logic [3:0]  s_gnt, w_gnt;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   int         m_ptr;
   int         m_cnt_s;
   int         m_cnt_w;
   logic [4:0] m_d;

   always #5 clk = ~clk;

   ud_counter_arbiter #(.N_REQ(4), .SIZE(5), .SATURATE(1)) dut_sat (
      .clk(clk), .rst_n(rst_n), .req(req), .op(op), .data(data), .cnt_q(sfr_s),
      .cnt_ld(s_ld), .cnt_incr(s_inc), .cnt_decr(s_dec), .cnt_d(s_d),
      .gnt(s_gnt), .err(s_err), .busy(s_busy)
   );

   ud_counter_arbiter #(.N_REQ(4), .SIZE(5), .SATURATE(0)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .req(req), .op(op), .data(data), .cnt_q(sfr_w),
      .cnt_ld(w_ld), .cnt_incr(w_inc), .cnt_decr(w_dec), .cnt_d(w_d),
      .gnt(w_gnt), .err(w_err), .busy(w_busy)
   );

   // Counter SFRs attached to each instance (environment, not reference)
   always @(posedge clk) begin
      if (set_en)     sfr_s <= set_val;
      else if (s_ld)  sfr_s <= s_d;
      else if (s_inc) sfr_s <= sfr_s + 5'd1;
      else if (s_dec) sfr_s <= sfr_s - 5'd1;
   end

   always @(posedge clk) begin
      if (set_en)     sfr_w <= set_val;
      else if (w_ld)  sfr_w <= w_d;
      else if (w_inc) sfr_w <= sfr_w + 5'd1;
      else if (w_dec) sfr_w <= sfr_w - 5'd1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at a negedge.
   task automatic do_reset();
      req   = '0;
      rst_n = 1'b0;
      #1;
      chk("rst_gnt",  {28'd0, s_gnt}, 32'd0);
      chk("rst_busy", {31'd0, s_busy}, 32'd0);
      chk("rst_strb", {29'd0, s_ld, s_inc, s_dec}, 32'd0);
      chk("rst_err",  {31'd0, s_err}, 32'd0);
      chk("rst_cntd", {27'd0, s_d}, 32'd0);
      chk("rst_cntd_w", {27'd0, w_d}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      m_ptr = 0;
      m_d   = '0;
   endtask

   task automatic set_cnt(input int v);
      req     = '0;
      set_en  = 1'b1;
      set_val = 5'(v);
      @(posedge clk);
      #1 set_en = 1'b0;
      m_cnt_s = v;
      m_cnt_w = v;
      @(negedge clk);
   endtask

   // One arbitration slot: IDLE cycle then (if granted) ISSUE cycle.
   task automatic run_slot(input logic [3:0] r, input logic [7:0] o, input logic [19:0] d);
      int         w;
      int         idx;
      logic [1:0] wop;
      logic [4:0] wd;
      logic       refuse;
      logic [3:0] e_gnt;
      logic [2:0] e_str_s, e_str_w;
      req  = r;
      op   = o;
      data = d;
      #1;
      chk("idle_gnt",  {28'd0, s_gnt}, 32'd0);
      chk("idle_busy", {31'd0, s_busy}, 32'd0);
      w = -1;
      for (int k = 0; k < 4; k++) begin
         idx = (m_ptr + k) % 4;
         if (w < 0 && r[idx]) w = idx;
      end
      e_gnt = '0; e_str_s = '0; e_str_w = '0; refuse = 1'b0; wop = 2'b00; wd = '0;
      if (w >= 0) begin
         wop    = o[2*w +: 2];
         wd     = d[5*w +: 5];
         e_gnt  = 4'(1 << w);
         refuse = (wop == 2'b01 && m_cnt_s == 31) || (wop == 2'b10 && m_cnt_s == 0);
         e_str_s = {wop == 2'b11, wop == 2'b01 && !refuse, wop == 2'b10 && !refuse};
         e_str_w = {wop == 2'b11, wop == 2'b01, wop == 2'b10};
         if (wop == 2'b11) begin
            m_d = wd; m_cnt_s = int'(wd); m_cnt_w = int'(wd);
         end else if (wop == 2'b01) begin
            if (!refuse) m_cnt_s = (m_cnt_s + 1) % 32;
            m_cnt_w = (m_cnt_w + 1) % 32;
         end else if (wop == 2'b10) begin
            if (!refuse) m_cnt_s = (m_cnt_s + 31) % 32;
            m_cnt_w = (m_cnt_w + 31) % 32;
         end
         m_ptr = (w + 1) % 4;
      end
      @(posedge clk);
      #1;
      chk("gnt_s",  {28'd0, s_gnt}, {28'd0, e_gnt});
      chk("gnt_w",  {28'd0, w_gnt}, {28'd0, e_gnt});
      chk("busy_s", {31'd0, s_busy}, {31'd0, w >= 0});
      chk("busy_w", {31'd0, w_busy}, {31'd0, w >= 0});
      chk("strb_s", {29'd0, s_ld, s_inc, s_dec}, {29'd0, e_str_s});
      chk("strb_w", {29'd0, w_ld, w_inc, w_dec}, {29'd0, e_str_w});
      chk("err_s",  {31'd0, s_err}, {31'd0, refuse});
      chk("err_w",  {31'd0, w_err}, 32'd0);
      chk("cntd_s", {27'd0, s_d}, {27'd0, m_d});
      chk("cntd_w", {27'd0, w_d}, {27'd0, m_d});
      @(posedge clk);
      #1;
      chk("cnt_s",  {27'd0, sfr_s}, 32'(m_cnt_s));
      chk("cnt_w",  {27'd0, sfr_w}, 32'(m_cnt_w));
      chk("busy_end", {31'd0, s_busy}, 32'd0);
      $display("slot req=%b op=%b win=%0d gnt=%b err=%b cnt_s=%0d cnt_w=%0d",
               r, o, w, s_gnt, s_err, sfr_s, sfr_w);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  r;
      logic [7:0]  o;
      logic [19:0] d;
      rst_n   = 1'b1;
      req     = '0;
      op      = '0;
      data    = '0;
      set_en  = 1'b0;
      set_val = '0;
      m_ptr = 0; m_cnt_s = 0; m_cnt_w = 0; m_d = '0;
      @(negedge clk);

      // Single INC from reset
      do_reset();
      set_cnt(5);
      run_slot(4'b0001, 8'b0000_0001, 20'd0);

      // Round-robin fairness, all requesters INC
      do_reset();
      set_cnt(0);
      repeat (5) run_slot(4'b1111, 8'b0101_0101, 20'd0);
      chk("fair_cnt", {27'd0, sfr_s}, 32'd5);

      // Saturation at both ends (wrap instance wraps instead)
      set_cnt(31);
      run_slot(4'b0100, 8'b0001_0000, 20'd0);
      set_cnt(0);
      run_slot(4'b0100, 8'b0010_0000, 20'd0);

      // LOAD then NOP
      run_slot(4'b0010, 8'b0000_1100, 20'(17 << 5));
      run_slot(4'b1000, 8'b0000_0000, 20'd0);
      chk("nop_cnt", {27'd0, sfr_s}, 32'd17);

      // Reset asserted in the middle of ISSUE
      do_reset();
      set_cnt(10);
      run_slot(4'b0001, 8'b0000_0001, 20'd0);
      req = 4'b1010;
      op  = 8'b0101_0101;
      @(posedge clk);
      #1;
      chk("mid_gnt_pre", {28'd0, s_gnt}, 32'b0010);
      rst_n = 1'b0;
      #1;
      chk("mid_gnt",  {28'd0, s_gnt}, 32'd0);
      chk("mid_busy", {31'd0, s_busy}, 32'd0);
      chk("mid_strb", {29'd0, s_ld, s_inc, s_dec}, 32'd0);
      chk("mid_gnt_w", {28'd0, w_gnt}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      m_ptr = 0;
      m_d   = '0;
      run_slot(4'b1010, 8'b0101_0101, 20'd0);

      // Randomized traffic
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 2))
               0:       set_cnt(0);
               1:       set_cnt(31);
               default: set_cnt(int'($urandom_range(0, 31)));
            endcase
         end
         r = 4'($urandom_range(0, 15));
         o = 8'($urandom);
         d = 20'($urandom);
         run_slot(r, o, d);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
